ale_window_3x3: RTL and testbench
=================================

Name: ale_window_3x3

Overview:
- Streaming 3x3 neighbourhood generator directly upstream of the atmospheric light estimation stage.
- Accepts one raster-order RGB888 pixel per accepted cycle and emits one 3x3 window per image pixel, exactly IMG_W*IMG_H windows per frame, in raster order of the window centre.
- Out-of-image neighbours are replaced by PAD_VALUE. The default of all-ones is neutral for the downstream minimum filters.
- Buffers two image lines internally and self-flushes the final line at end of frame.

Parameters:
- IMG_W, 512, pixels per line (>=4).
- IMG_H, 512, lines per frame (>=3).
- PAD_VALUE, 24'hFFFFFF, substituted for any neighbour outside the image.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_pixel is valid this cycle.
- in_ready, output, 1, block can accept a pixel. A pixel is accepted when in_valid && in_ready.
- in_pixel, input, 24, R[23:16] G[15:8] B[7:0].
- out_valid, output, 1, window outputs valid. Single-cycle strobe per window.
- out_pixel_1..out_pixel_9, output, 24 each, window in row-major order: 1..3 = row above (left, centre, right), 4..6 = centre row, 5 = centre pixel, 7..9 = row below.
- frame_done, output, 1, one-cycle pulse coincident with out_valid of the last window of a frame.

Behaviour:
- Reset values: in_ready=1 (from the first cycle after reset), out_valid=0, frame_done=0, all out_pixel_n=0. Internal counters are cleared and the FSM goes to STREAM.
- Stream index: k counts 0..N+W, where N=IMG_H*IMG_W and W=IMG_W.
  - k<N are accepted input pixels.
  - k=N..N+W are W+1 internally generated flush slots; their sample value is don't-care because it is always masked.
- Window emission: when slot k is consumed (accepted pixel or flush slot) and k>=W+1, the window centred on raster index c=k-W-1 is registered. out_valid=1 on the next cycle. Latency is 1 cycle after the acceptance of stream slot k.
- Windows emitted: exactly N per frame, centres 0..N-1 in order. No window is emitted for k<=W.
- Storage: two line delays of W pixels plus a 3x3 register array, or an equivalent 2W+3 tap delay.
  - Taps at k-2W-2 .. k. The newest tap (k) is the bottom-right neighbour (out_pixel_9).
  - Line storage is one RAM per line or shift registers. The choice is free, provided there is no combinational path from in_pixel to outputs.
- Padding: centre row cr and column cc are tracked with counters, not division. Masks are applied to the registered outputs:
  - cr==0: out_pixel_1..3 = PAD_VALUE.
  - cr==IMG_H-1: out_pixel_7..9 = PAD_VALUE.
  - cc==0: out_pixel_1,4,7 = PAD_VALUE.
  - cc==IMG_W-1: out_pixel_3,6,9 = PAD_VALUE.
  - Corners combine masks; e.g. centre (0,0) pads 1,2,3,4,7.
- Masking guarantees data from the previous frame and from line wrap-around never reaches the outputs.
- FSM:
  - STREAM: in_ready=1. A slot is consumed only on in_valid. Gaps in in_valid stall everything; out_valid stays 0 during gaps and no state advances. On acceptance of pixel N-1, go to FLUSH.
  - FLUSH: in_ready=0. One flush slot is consumed every cycle for exactly W+1 cycles, regardless of in_valid. The last slot asserts frame_done with its window, then the FSM returns to STREAM with k, cr and cc cleared.
- Back-to-back frames: the first pixel of the next frame may be accepted the cycle after FLUSH ends. The new frame is independent of the old one.
- No output backpressure: the consumer must accept every out_valid strobe.
- rst mid-frame: the next cycle has out_valid=0, frame_done=0, STREAM with k=0. Partial-frame data is discarded and never emitted.
- in_valid while in_ready=0 is ignored and the pixel is not consumed. The upstream source must hold it.

Test Plan:
1. Small frame, IMG_W=4, IMG_H=3, in_pixel = raster index (0..11), in_valid held high. Required:
   - First out_valid occurs 1 cycle after pixel 5 is accepted.
   - Window 0 = {PAD,PAD,PAD, PAD,0,1, PAD,4,5}.
   - Window 5 (centre 5) = {0,1,2,4,5,6,8,9,10}.
   - Window 11 = {6,7,PAD, 10,11,PAD, PAD,PAD,PAD}.
   - Exactly 12 strobes. frame_done is high only with window 11.
2. Flush timing, same configuration. Required: in_ready=0 for exactly 5 cycles after pixel 11 is accepted, and in_valid during that period is ignored. in_ready=1 again the cycle after frame_done.
3. Random in_valid gaps with ~40% duty, same data. Required: window sequence identical to scenario 1, and no out_valid during stalls.
4. Two back-to-back frames: frame A all 24'h000000, frame B all 24'h101010. Required: no frame-B window contains 24'h000000; top-row neighbours of frame B are PAD.
5. Reset asserted after 7 pixels, then a full frame is sent. Required: out_valid=0 the cycle after rst, and exactly 12 windows matching scenario 1.
6. Default 512x512 frame with pixel value = {row[7:0], col[7:0], 8'h00}. Required: 262144 strobes, one frame_done, and spot-check centre (0,511) and (511,0) masks.

Source files
------------

// File: rtl/ale_window_3x3.sv
// rtl/ale_window_3x3.sv - streaming 3x3 RGB888 neighbourhood generator with edge padding
// Feeds the atmospheric light estimation stage; self-flushes the last line at end of frame.
module ale_window_3x3 #(
   parameter int          IMG_W     = 512,
   parameter int          IMG_H     = 512,
   parameter logic [23:0] PAD_VALUE = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_pixel,
   output logic        out_valid,
   output logic [23:0] out_pixel_1,
   output logic [23:0] out_pixel_2,
   output logic [23:0] out_pixel_3,
   output logic [23:0] out_pixel_4,
   output logic [23:0] out_pixel_5,
   output logic [23:0] out_pixel_6,
   output logic [23:0] out_pixel_7,
   output logic [23:0] out_pixel_8,
   output logic [23:0] out_pixel_9,
   output logic        frame_done
);

   localparam int N     = IMG_W * IMG_H;
   localparam int LAST  = N + IMG_W;
   localparam int KW    = $clog2(LAST + 1);
   localparam int CRW   = $clog2(IMG_H);
   localparam int CCW   = $clog2(IMG_W);
   localparam int DEPTH = 2 * IMG_W + 2;

   typedef enum logic {STREAM, FLUSH} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [KW-1:0]  k;
   logic [CRW-1:0] cr;
   logic [CCW-1:0] cc;
   logic [23:0]    sr [DEPTH];
   logic           consume;
   logic           emit;
   logic           last_slot;
   logic           top;
   logic           bot;
   logic           lft;
   logic           rgt;

   always_ff @(posedge clk) begin
      if (rst) state <= STREAM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      consume   = 1'b0;
      case (state)
         STREAM: begin
            in_ready = 1'b1;
            consume  = in_valid;
            if (in_valid && k == KW'(N - 1)) state_nxt = FLUSH;
         end
         FLUSH: begin
            consume = 1'b1;
            if (k == KW'(LAST)) state_nxt = STREAM;
         end
         default: state_nxt = STREAM;
      endcase
   end

   assign emit      = consume && (k >= KW'(IMG_W + 1));
   assign last_slot = consume && (k == KW'(LAST));

   // k is the stream slot index; cr/cc follow the centre of the next window to emit
   always_ff @(posedge clk) begin
      if (rst) begin
         k  <= '0;
         cr <= '0;
         cc <= '0;
      end else begin
         if (consume) k <= last_slot ? '0 : k + 1'b1;
         if (last_slot) begin
            cr <= '0;
            cc <= '0;
         end else if (emit) begin
            if (cc == CCW'(IMG_W - 1)) begin
               cc <= '0;
               cr <= cr + 1'b1;
            end else begin
               cc <= cc + 1'b1;
            end
         end
      end
   end

   // sr[i] holds slot k-1-i; stale or flush data only ever sits in masked taps
   always_ff @(posedge clk) begin
      if (consume) begin
         sr[0] <= in_pixel;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign top = (cr == '0);
   assign bot = (cr == CRW'(IMG_H - 1));
   assign lft = (cc == '0);
   assign rgt = (cc == CCW'(IMG_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         frame_done  <= 1'b0;
         out_pixel_1 <= '0;
         out_pixel_2 <= '0;
         out_pixel_3 <= '0;
         out_pixel_4 <= '0;
         out_pixel_5 <= '0;
         out_pixel_6 <= '0;
         out_pixel_7 <= '0;
         out_pixel_8 <= '0;
         out_pixel_9 <= '0;
      end else begin
         out_valid  <= emit;
         frame_done <= last_slot;
         if (emit) begin
            out_pixel_1 <= (top || lft) ? PAD_VALUE : sr[2*IMG_W+1];
            out_pixel_2 <= top          ? PAD_VALUE : sr[2*IMG_W];
            out_pixel_3 <= (top || rgt) ? PAD_VALUE : sr[2*IMG_W-1];
            out_pixel_4 <= lft          ? PAD_VALUE : sr[IMG_W+1];
            out_pixel_5 <= sr[IMG_W];
            out_pixel_6 <= rgt          ? PAD_VALUE : sr[IMG_W-1];
            out_pixel_7 <= (bot || lft) ? PAD_VALUE : sr[1];
            out_pixel_8 <= bot          ? PAD_VALUE : sr[0];
            out_pixel_9 <= (bot || rgt) ? PAD_VALUE : in_pixel;
         end
      end
   end

endmodule

// File: tb/tb_ale_window_3x3.sv
// tb/tb_ale_window_3x3.sv - randomized self-checking bench for ale_window_3x3
// Expected windows come from the image array and row/column neighbour arithmetic.
module tb_ale_window_3x3;

   localparam int          W   = 4;
   localparam int          H   = 3;
   localparam int          N   = W * H;
   localparam logic [23:0] PAD = 24'hFFFFFF;

   typedef logic [215:0] word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_pixel;
   logic        out_valid;
   logic [23:0] out_pixel_1, out_pixel_2, out_pixel_3;
   logic [23:0] out_pixel_4, out_pixel_5, out_pixel_6;
   logic [23:0] out_pixel_7, out_pixel_8, out_pixel_9;
   logic        frame_done;

   always #5 clk = ~clk;

   ale_window_3x3 #(.IMG_W(W), .IMG_H(H), .PAD_VALUE(PAD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .out_valid(out_valid),
      .out_pixel_1(out_pixel_1), .out_pixel_2(out_pixel_2), .out_pixel_3(out_pixel_3),
      .out_pixel_4(out_pixel_4), .out_pixel_5(out_pixel_5), .out_pixel_6(out_pixel_6),
      .out_pixel_7(out_pixel_7), .out_pixel_8(out_pixel_8), .out_pixel_9(out_pixel_9),
      .frame_done(frame_done)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   logic [23:0] img [N];
   word_t win_log [N];
   word_t ref_log [N];
   int    bk       = 0;
   bit    flushing = 1'b0;
   bit    frame_end;
   int    cyc      = 0;
   int    strobes, dones, ready_low, acc5_cyc, first_strobe_cyc;

   task automatic check_eq(input string tag, input word_t obs, input word_t exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic word_t exp_win(input int c);
      int    r, col, rr, cx;
      word_t w;
      w   = '0;
      r   = c / W;
      col = c % W;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cx = col + dc;
            w  = w << 24;
            if (rr < 0 || rr >= H || cx < 0 || cx >= W) w[23:0] = PAD;
            else                                        w[23:0] = img[rr*W + cx];
         end
      end
      return w;
   endfunction

   function automatic word_t obs_win();
      return {out_pixel_1, out_pixel_2, out_pixel_3, out_pixel_4, out_pixel_5,
              out_pixel_6, out_pixel_7, out_pixel_8, out_pixel_9};
   endfunction

   // one clock: drive, let the edge happen, then compare against the slot model
   task automatic step(input bit v, input logic [23:0] px);
      bit cons, emit, last;
      int slot;
      in_valid = v;
      in_pixel = px;
      check_eq("in_ready", word_t'(in_ready), word_t'(!flushing));
      if (!in_ready) ready_low++;
      cons = flushing || v;
      slot = bk;
      emit = cons && (slot >= W + 1);
      last = cons && (slot == N + W);
      if (cons && !flushing && slot == 5) acc5_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      check_eq("out_valid", word_t'(out_valid), word_t'(emit));
      check_eq("frame_done", word_t'(frame_done), word_t'(last));
      if (emit) begin
         check_eq($sformatf("win_c%0d", slot - W - 1), obs_win(), exp_win(slot - W - 1));
         win_log[slot - W - 1] = obs_win();
         strobes++;
      end
      if (out_valid && first_strobe_cyc < 0) first_strobe_cyc = cyc;
      if (frame_done) dones++;
      frame_end = last;
      if (cons) begin
         if (last) begin
            bk       = 0;
            flushing = 1'b0;
         end else begin
            bk++;
            if (bk == N) flushing = 1'b1;
         end
      end
   endtask

   task automatic do_reset(input bit v);
      rst      = 1'b1;
      in_valid = v;
      in_pixel = 24'h0;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      check_eq("rst_out_valid", word_t'(out_valid), word_t'(0));
      check_eq("rst_frame_done", word_t'(frame_done), word_t'(0));
      check_eq("rst_in_ready", word_t'(in_ready), word_t'(1));
      check_eq("rst_pixels", obs_win(), word_t'(0));
      bk       = 0;
      flushing = 1'b0;
   endtask

   task automatic run_frame(input int gap_pct);
      int guard;
      guard            = 0;
      strobes          = 0;
      dones            = 0;
      ready_low        = 0;
      acc5_cyc         = -1;
      first_strobe_cyc = -1;
      frame_end        = 1'b0;
      while (!frame_end && guard < 2000) begin
         if (flushing) step(1'($urandom_range(1)), 24'($urandom));
         else          step(($urandom_range(99) >= gap_pct), img[bk]);
         guard++;
      end
      check_eq("frame_bound", word_t'(frame_end), word_t'(1));
      check_eq("strobe_count", word_t'(strobes), word_t'(N));
      check_eq("frame_done_count", word_t'(dones), word_t'(1));
      check_eq("ready_low_cycles", word_t'(ready_low), word_t'(W + 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int zeros;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_pixel = 24'h0;
      @(posedge clk);
      #1;
      do_reset(1'b0);

      // raster-index frame, no gaps
      for (int i = 0; i < N; i++) img[i] = 24'(i);
      run_frame(0);
      check_eq("first_strobe_latency", word_t'(first_strobe_cyc - acc5_cyc), word_t'(1));
      check_eq("win0_const", win_log[0],
               {PAD, PAD, PAD, PAD, 24'd0, 24'd1, PAD, 24'd4, 24'd5});
      check_eq("win5_const", win_log[5],
               {24'd0, 24'd1, 24'd2, 24'd4, 24'd5, 24'd6, 24'd8, 24'd9, 24'd10});
      check_eq("win11_const", win_log[11],
               {24'd6, 24'd7, PAD, 24'd10, 24'd11, PAD, PAD, PAD, PAD});
      for (int i = 0; i < N; i++) ref_log[i] = win_log[i];

      // same data with ~40% input gaps
      run_frame(40);
      for (int i = 0; i < N; i++) check_eq($sformatf("gap_win%0d", i), win_log[i], ref_log[i]);

      // back-to-back frames: zeros then 0x101010
      for (int i = 0; i < N; i++) img[i] = 24'h000000;
      run_frame(0);
      for (int i = 0; i < N; i++) img[i] = 24'h101010;
      run_frame(0);
      zeros = 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < 9; j++) if (win_log[i][24*j +: 24] == 24'h0) zeros++;
      end
      check_eq("frameB_no_zero", word_t'(zeros), word_t'(0));
      for (int c = 0; c < W; c++)
         check_eq($sformatf("frameB_top_pad%0d", c), word_t'(win_log[c][215:144]),
                  word_t'({PAD, PAD, PAD}));

      // reset after 7 pixels, then a full frame
      for (int i = 0; i < N; i++) img[i] = 24'(i);
      while (bk < 7) step(1'b1, img[bk]);
      do_reset(1'b1);
      run_frame(0);
      for (int i = 0; i < N; i++) check_eq($sformatf("rst_win%0d", i), win_log[i], ref_log[i]);

      // random data with random gap density
      repeat (4) begin
         for (int i = 0; i < N; i++) img[i] = 24'($urandom);
         run_frame(int'($urandom_range(60)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
